bs_mac_array: RTL and testbench

- Parametrised multi-lane bit-serial multiply-accumulate engine. Successor to the single-lane serial MAC.
- N_LANES lanes share one serial activation stream. Each lane holds its own sign-magnitude weight, receives its own serial partial-sum input, and emits its own serial result.
- An internal frame controller generates the first-bit (plus-one) and enable timing that external logic previously drove by hand.
- Weights are double-buffered, so the next weight can be loaded while the current frame runs.

---
 rtl/bs_mac_array.sv | 224 ++++++++++++++++++++++
 tb/tb_bs_mac_array.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/bs_mac_array.sv
// Multi-lane bit-serial multiply-accumulate engine with shared activation
// stream, per-lane sign-magnitude double-buffered weights and an internal
// frame controller. Result bit k leaves two cycles after input bit k.
module bs_mac_array #(
    parameter int unsigned N_LANES  = 4,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned WEIGHT_W = 8,
    parameter int unsigned ACC_W    = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_start,
    input  logic               data_bit,
    input  logic [N_LANES-1:0] acc_bit,
    input  logic               w_load,
    input  logic [N_LANES-1:0] w_bit,
    input  logic [N_LANES-1:0] w_sign,
    output logic [N_LANES-1:0] res_bit,
    output logic               res_valid,
    output logic               res_first,
    output logic               busy,
    output logic               w_ready,
    output logic               frame_err
);

    localparam int unsigned KW    = (ACC_W > 1) ? $clog2(ACC_W) : 1;
    localparam int unsigned CNT_W = 5;

    localparam logic [KW-1:0]    K_LAST = KW'(ACC_W - 1);
    localparam logic [KW-1:0]    K_DATA = KW'(DATA_W);
    localparam logic [CNT_W-1:0] W_BITS = CNT_W'(WEIGHT_W);
    localparam logic [CNT_W-1:0] W_LAST = CNT_W'(WEIGHT_W - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Frame controller; k indexes the bit held in the input stage register
    logic [0:0]    state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic          start_ok;
    logic          start_err;

    // Input stage: bit k sits here while the lanes process it
    logic               data_q;
    logic [N_LANES-1:0] acc_q;

    // Weight buffers
    logic [CNT_W-1:0]                   wcnt_q, wcnt_d;
    logic [N_LANES-1:0][WEIGHT_W-1:0]   shadow_mag_q, shadow_mag_d;
    logic [N_LANES-1:0]                 shadow_sign_q, shadow_sign_d;
    logic [N_LANES-1:0][WEIGHT_W-1:0]   act_mag_q, act_mag_d;
    logic [N_LANES-1:0]                 act_sign_q, act_sign_d;
    logic                               w_ready_q, w_ready_d;
    logic                               frame_err_q, frame_err_d;
    logic                               load_take;
    logic                               load_over;
    logic                               commit;

    // Lane datapath: carry-save multiplier chain plus serial adder carry
    logic [N_LANES-1:0][WEIGHT_W-1:0]   s_q, s_d;
    logic [N_LANES-1:0][WEIGHT_W-1:0]   c_q, c_d;
    logic [N_LANES-1:0]                 add_c_q, add_c_d;
    logic [N_LANES-1:0]                 res_bit_q, res_bit_d;
    logic                               res_valid_q;
    logic                               res_first_q;

    // Frame FSM next state: IDLE/RUN with bit counter, back-to-back restart at the last bit
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        start_ok  = 1'b0;
        start_err = 1'b0;
        case (state_q)
            ST_IDLE: begin
                k_d = '0;
                if (frame_start) begin
                    state_d  = ST_RUN;
                    start_ok = 1'b1;
                end
            end
            ST_RUN: begin
                if (k_q == K_LAST) begin
                    k_d = '0;
                    if (frame_start) begin
                        start_ok = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    k_d = k_q + KW'(1);
                    if (frame_start) begin
                        start_err = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                k_d     = '0;
            end
        endcase
    end

    // Weight load shifting, commit on accepted frame start, sticky error
    always_comb begin
        load_take     = w_load && (wcnt_q < W_BITS);
        load_over     = w_load && !load_take;
        commit        = start_ok && w_ready_q;
        wcnt_d        = w_load ? (load_take ? wcnt_q + CNT_W'(1) : wcnt_q) : '0;
        shadow_mag_d  = shadow_mag_q;
        shadow_sign_d = shadow_sign_q;
        act_mag_d     = act_mag_q;
        act_sign_d    = act_sign_q;
        w_ready_d     = w_ready_q;
        frame_err_d   = frame_err_q | start_err | load_over;
        if (load_take) begin
            for (int l = 0; l < int'(N_LANES); l++) begin
                shadow_mag_d[l] = {w_bit[l], shadow_mag_q[l][WEIGHT_W-1:1]};
            end
            if (wcnt_q == '0) begin
                shadow_sign_d = w_sign;
            end
        end
        // Commit reads the shadow as it stood before this cycle's load activity
        if (commit) begin
            act_mag_d  = shadow_mag_q;
            act_sign_d = shadow_sign_q;
        end
        if (load_take && (wcnt_q == W_LAST)) begin
            w_ready_d = 1'b1;
        end else if (load_take && (wcnt_q == '0)) begin
            w_ready_d = 1'b0;
        end else if (commit) begin
            w_ready_d = 1'b0;
        end
    end

    // Per-lane serial multiply, conditional negate, and accumulate
    always_comb begin : lane_math
        logic                x;
        logic                first;
        logic [WEIGHT_W-1:0] s_eff;
        logic [WEIGHT_W-1:0] c_eff;
        logic [WEIGHT_W-1:0] s_sh;
        logic                pp;
        logic                p;
        logic                ci;
        x     = data_q & (k_q < K_DATA);
        first = (k_q == '0);
        s_eff = '0;
        c_eff = '0;
        s_sh  = '0;
        pp    = 1'b0;
        p     = 1'b0;
        ci    = 1'b0;
        s_d       = '0;
        c_d       = '0;
        add_c_d   = '0;
        res_bit_d = '0;
        for (int l = 0; l < int'(N_LANES); l++) begin
            s_eff = first ? '0 : s_q[l];
            c_eff = first ? '0 : c_q[l];
            s_sh  = s_eff >> 1;
            for (int j = 0; j < int'(WEIGHT_W); j++) begin
                pp         = x & act_mag_q[l][j];
                s_d[l][j]  = pp ^ s_sh[j] ^ c_eff[j];
                c_d[l][j]  = (pp & s_sh[j]) | (pp & c_eff[j]) | (s_sh[j] & c_eff[j]);
            end
            // Negation is ~P + 1: invert product bits, inject the +1 as adder carry-in at bit 0
            p            = s_d[l][0] ^ act_sign_q[l];
            ci           = first ? act_sign_q[l] : add_c_q[l];
            res_bit_d[l] = p ^ acc_q[l] ^ ci;
            add_c_d[l]   = (p & acc_q[l]) | (p & ci) | (acc_q[l] & ci);
        end
    end

    // State, weight and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            k_q           <= '0;
            data_q        <= 1'b0;
            acc_q         <= '0;
            wcnt_q        <= '0;
            shadow_mag_q  <= '0;
            shadow_sign_q <= '0;
            act_mag_q     <= '0;
            act_sign_q    <= '0;
            w_ready_q     <= 1'b0;
            frame_err_q   <= 1'b0;
            s_q           <= '0;
            c_q           <= '0;
            add_c_q       <= '0;
            res_bit_q     <= '0;
            res_valid_q   <= 1'b0;
            res_first_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            data_q        <= data_bit;
            acc_q         <= acc_bit;
            wcnt_q        <= wcnt_d;
            shadow_mag_q  <= shadow_mag_d;
            shadow_sign_q <= shadow_sign_d;
            act_mag_q     <= act_mag_d;
            act_sign_q    <= act_sign_d;
            w_ready_q     <= w_ready_d;
            frame_err_q   <= frame_err_d;
            s_q           <= s_d;
            c_q           <= c_d;
            add_c_q       <= add_c_d;
            res_bit_q     <= (state_q == ST_RUN) ? res_bit_d : '0;
            res_valid_q   <= (state_q == ST_RUN);
            res_first_q   <= (state_q == ST_RUN) && (k_q == '0);
        end
    end

    assign res_bit   = res_bit_q;
    assign res_valid = res_valid_q;
    assign res_first = res_first_q;
    assign busy      = (state_q == ST_RUN);
    assign w_ready   = w_ready_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_bs_mac_array.sv
// Directed bench for bs_mac_array: inputs driven and outputs sampled on the falling edge.
module tb_bs_mac_array;

    localparam int NL = 4;
    localparam int DW = 8;
    localparam int WW = 8;
    localparam int AW = 32;

    logic          clk;
    logic          reset;
    logic          frame_start;
    logic          data_bit;
    logic [NL-1:0] acc_bit;
    logic          w_load;
    logic [NL-1:0] w_bit;
    logic [NL-1:0] w_sign;
    logic [NL-1:0] res_bit;
    logic          res_valid;
    logic          res_first;
    logic          busy;
    logic          w_ready;
    logic          frame_err;

    int checks;
    int failures;

    bs_mac_array #(
        .N_LANES (NL),
        .DATA_W  (DW),
        .WEIGHT_W(WW),
        .ACC_W   (AW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .frame_start(frame_start),
        .data_bit   (data_bit),
        .acc_bit    (acc_bit),
        .w_load     (w_load),
        .w_bit      (w_bit),
        .w_sign     (w_sign),
        .res_bit    (res_bit),
        .res_valid  (res_valid),
        .res_first  (res_first),
        .busy       (busy),
        .w_ready    (w_ready),
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Load the same-cycle weight of every lane; sign differs after the first cycle on purpose
    task automatic load_w(input logic [NL-1:0][WW-1:0] mag, input logic [NL-1:0] sgn);
        for (int i = 0; i < WW; i++) begin
            @(negedge clk);
            w_load = 1'b1;
            for (int l = 0; l < NL; l++) w_bit[l] = mag[l][i];
            w_sign = (i == 0) ? sgn : ~sgn;
        end
        @(negedge clk);
        w_load = 1'b0;
        w_bit  = '0;
        w_sign = '0;
    endtask

    // One frame; optional stray frame_start at input cycle extra_at
    task automatic run_frame(input logic [DW-1:0] data, input logic [NL-1:0][AW-1:0] acc,
                             input int extra_at, output logic [NL-1:0][AW-1:0] res,
                             output int nvalid, output int first_at, output int nbusy);
        res = '0; nvalid = 0; first_at = -1; nbusy = 0;
        for (int i = 0; i <= AW + 2; i++) begin
            @(negedge clk);
            if (res_valid) nvalid++;
            if (res_first && first_at < 0) first_at = i;
            if (busy) nbusy++;
            if (i >= 2 && i < AW + 2)
                for (int l = 0; l < NL; l++) res[l][i-2] = res_bit[l];
            frame_start = (i == 0) || (i == extra_at);
            if (i < DW) data_bit = data[i];
            else        data_bit = 1'($urandom());
            for (int l = 0; l < NL; l++) begin
                if (i < AW) acc_bit[l] = acc[l][i];
                else        acc_bit[l] = 1'($urandom());
            end
        end
        frame_start = 1'b0;
    endtask

    logic [NL-1:0][AW-1:0] res;
    logic [NL-1:0][AW-1:0] res_b;
    int nvalid, first_at, nbusy, nfirst, gaps, fgood;
    logic wr_before, wr_after;
    logic [DW-1:0] d4;
    logic [AW-1:0] a1;
    logic [WW-1:0] m7;
    logic [WW-1:0] m5;

    initial begin
        checks = 0; failures = 0;
        reset = 1'b1; frame_start = 1'b0; data_bit = 1'b0; acc_bit = '0;
        w_load = 1'b0; w_bit = '0; w_sign = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_res_bit", 128'(res_bit), 128'(0));
        check("rst_res_valid", 128'(res_valid), 128'(0));
        check("rst_res_first", 128'(res_first), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_w_ready", 128'(w_ready), 128'(0));
        check("rst_frame_err", 128'(frame_err), 128'(0));

        // Mixed-sign lanes including -0
        load_w({8'd0, 8'd0, 8'd10, 8'd3}, 4'b1010);
        check("t1_w_ready_loaded", 128'(w_ready), 128'(1));
        run_frame(8'd5, {4{32'hFFFF_FFF6}}, -1, res, nvalid, first_at, nbusy);
        check("t1_results", 128'(res), {32'hFFFF_FFF6, 32'hFFFF_FFF6, 32'hFFFF_FFC4, 32'd5});
        check("t1_first_latency", 128'(first_at), 128'(2));
        check("t1_w_ready_cleared", 128'(w_ready), 128'(0));

        // Negative weight, valid window length
        load_w({4{8'd10}}, 4'b1111);
        run_frame(8'd9, {4{32'd9}}, -1, res, nvalid, first_at, nbusy);
        check("t2_results", 128'(res), {4{32'hFFFF_FFAF}});
        check("t2_valid_len", 128'(nvalid), 128'(32));
        check("t2_first_pos", 128'(first_at), 128'(2));

        // Wrap-around
        load_w({4{8'd255}}, 4'b0000);
        run_frame(8'd255, {4{32'h7FFF_FFFF}}, -1, res, nvalid, first_at, nbusy);
        check("t3_results", 128'(res), {4{32'h8000_FE00}});
        check("t3_frame_err", 128'(frame_err), 128'(0));

        // Back-to-back frames with a load of +7 during frame A
        load_w({4{8'd2}}, 4'b0000);
        d4 = 8'd4; a1 = 32'd1; m7 = 8'd7;
        res = '0; res_b = '0; nvalid = 0; nfirst = 0; gaps = 0; fgood = 0;
        wr_before = 1'b0; wr_after = 1'b1;
        for (int i = 0; i <= 2 * AW + 2; i++) begin
            @(negedge clk);
            if (res_valid) nvalid++;
            if (i >= 2 && i < 2 * AW + 2 && !res_valid) gaps++;
            if (res_first) begin
                nfirst++;
                if (i == 2 || i == AW + 2) fgood++;
            end
            if (i >= 2 && i < AW + 2)
                for (int l = 0; l < NL; l++) res[l][i-2] = res_bit[l];
            if (i >= AW + 2 && i < 2 * AW + 2)
                for (int l = 0; l < NL; l++) res_b[l][i-AW-2] = res_bit[l];
            if (i == AW) wr_before = w_ready;
            if (i == AW + 1) wr_after = w_ready;
            frame_start = (i == 0) || (i == AW);
            if (i < 2 * AW) begin
                data_bit = ((i % AW) < DW) ? d4[i % AW] : 1'($urandom());
                acc_bit  = {NL{a1[i % AW]}};
            end else begin
                data_bit = 1'($urandom());
                acc_bit  = '0;
            end
            w_load = (i >= 5 && i < 5 + WW);
            w_bit  = (i >= 5 && i < 5 + WW) ? {NL{m7[i-5]}} : '0;
            w_sign = '0;
        end
        frame_start = 1'b0; w_load = 1'b0;
        check("t4_frame_a", 128'(res), {4{32'd9}});
        check("t4_frame_b", 128'(res_b), {4{32'd29}});
        check("t4_valid_gaps", 128'(gaps), 128'(0));
        check("t4_valid_total", 128'(nvalid), 128'(64));
        check("t4_first_marks", 128'({nfirst[7:0], fgood[7:0]}), 128'(16'h0202));
        check("t4_w_ready_edge", 128'({wr_before, wr_after}), 128'(2'b10));
        check("t4_frame_err", 128'(frame_err), 128'(0));

        // Stray frame_start at k=10
        load_w({4{8'd2}}, 4'b0000);
        run_frame(8'd3, {4{32'd0}}, 11, res, nvalid, first_at, nbusy);
        check("t5_results", 128'(res), {4{32'd6}});
        check("t5_frame_err", 128'(frame_err), 128'(1));
        check("t5_busy_len", 128'(nbusy), 128'(32));

        // Reset at k=12
        for (int i = 0; i <= 14; i++) begin
            @(negedge clk);
            if (i == 13) check("t6_pre_reset_busy", 128'({busy, res_valid}), 128'(2'b11));
            if (i == 14) begin
                check("t6_post_reset_busy", 128'(busy), 128'(0));
                check("t6_post_reset_valid", 128'(res_valid), 128'(0));
            end
            frame_start = (i == 0);
            data_bit    = 1'($urandom());
            acc_bit     = NL'($urandom());
            reset       = (i == 13);
        end
        reset = 1'b0; frame_start = 1'b0;
        nvalid = 0;
        repeat (3) begin
            @(negedge clk);
            if (res_valid) nvalid++;
        end
        check("t6_no_partial", 128'(nvalid), 128'(0));
        check("t6_flags_cleared", 128'({w_ready, frame_err}), 128'(0));
        run_frame(8'd77, {4{32'd123}}, -1, res, nvalid, first_at, nbusy);
        check("t6_results", 128'(res), {4{32'd123}});

        // Overlong load: ninth bit ignored, error flagged
        m5 = 8'd5;
        for (int i = 0; i < WW + 1; i++) begin
            @(negedge clk);
            w_load = 1'b1;
            w_bit  = (i < WW) ? {NL{m5[i]}} : {NL{1'b1}};
            w_sign = '0;
        end
        @(negedge clk);
        w_load = 1'b0; w_bit = '0;
        check("t7_flags", 128'({w_ready, frame_err}), 128'(2'b11));
        run_frame(8'd3, {4{32'd0}}, -1, res, nvalid, first_at, nbusy);
        check("t7_results", 128'(res), {4{32'd15}});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
